registrador_pipeline: RTL and testbench
=======================================

Name: registrador_pipeline

Overview:
Parametrised successor to the team's single-bit async-reset D flip-flop. Provides a WIDTH-bit, DEPTH-stage register pipeline with a valid tag per stage, a global stall enable, a synchronous flush, a programmable reset value, and a running count of occupied stages. Used wherever sensor and control words are delayed or retimed between the acquisition and control blocks.

Parameters:
WIDTH, 8, data word width in bits; must be >= 1.
DEPTH, 3, number of pipeline stages, equal to the latency in enabled cycles; must be >= 1.
RESET_VALUE, 0, WIDTH-bit value loaded into every data stage on reset and on CLEAR.

Ports:
CLOCK  input  1  single clock; all state updates on its rising edge.
RESET  input  1  asynchronous, active-low reset.
ENABLE  input  1  1 = pipeline advances; 0 = all stages hold.
CLEAR  input  1  synchronous flush, active high.
D  input  WIDTH  input data word.
D_VALID  input  1  marks D as valid.
Q  output  WIDTH  data word of the last stage.
Q_VALID  output  1  valid tag of the last stage.
OCCUPANCY  output  $clog2(DEPTH+1)  number of stages with a set valid tag.
Q_CHANGED  output  1  one-cycle pulse after the last stage loads valid data that differs from the previous Q.

Behaviour:
- Interface: one clock, CLOCK. Reset is asynchronous and active-low on RESET.
- Reset (RESET=0): takes effect immediately, with no clock edge needed.
  - Every data stage = RESET_VALUE.
  - All valid tags = 0.
  - OCCUPANCY = 0, Q_CHANGED = 0.
  - These values hold for as long as RESET=0.
- Priority at each rising edge: RESET, then CLEAR, then ENABLE.
- CLEAR=1 at an edge:
  - All data stages = RESET_VALUE, all valid tags = 0, OCCUPANCY = 0, Q_CHANGED = 0.
  - Applies regardless of ENABLE, so a flush works while stalled.
  - D and D_VALID are discarded that cycle.
- ENABLE=1 and CLEAR=0 at an edge:
  - stage[0] <= {D, D_VALID}.
  - stage[i] <= stage[i-1] for i = 1..DEPTH-1.
  - Q and Q_VALID are driven from stage[DEPTH-1].
- Latency: a word accepted at edge k appears on Q after edge k+DEPTH-1, counting enabled edges only.
- Invalid words (D_VALID=0) still shift their data bits; only the tag marks them invalid.
- ENABLE=0 and CLEAR=0:
  - All stages and OCCUPANCY hold.
  - Q_CHANGED = 0.
- OCCUPANCY:
  - Registered; after every edge it equals the number of set valid tags.
  - Update rule on an enabled edge: +1 if D_VALID=1 and the tag of stage[DEPTH-1] was 0; −1 if D_VALID=0 and that tag was 1; otherwise unchanged.
  - Range 0..DEPTH; it never wraps.
- Q_CHANGED:
  - Registered.
  - Set to 1 at an enabled edge when stage[DEPTH-1] loads a valid word whose data differs from Q before the edge.
  - Otherwise 0, so it is never high for two consecutive cycles unless the data changes again.
- DEPTH=1:
  - Single stage; latency 1.
  - OCCUPANCY is 1 bit wide and equals Q_VALID.
- Reset mid-operation: in-flight words are lost with no partial state; the pipeline restarts empty.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package (constants only):
  - Occupancy width function, $clog2(DEPTH+1), with a floor of 1 bit.
  - Default WIDTH and DEPTH.
- One natural sub-module, estagio_registro:
  - Contains a WIDTH+1-bit register with async active-low reset to {RESET_VALUE, 0}, synchronous clear, and enable.
  - Instantiated DEPTH times in a generate loop.
  - OCCUPANCY and Q_CHANGED logic lives in the top module.

Test Plan:
- Reset: drive RESET=0 mid-cycle with RESET_VALUE=8'hA5 → Q=8'hA5, Q_VALID=0 and OCCUPANCY=0 immediately, before any clock edge; these values hold for 3 clocks with RESET still low.
- Latency (DEPTH=3, ENABLE=1): D=8'h11, 8'h22, 8'h33, each with D_VALID=1, on consecutive edges → Q=8'h11 with Q_VALID=1 after the 3rd edge; OCCUPANCY reads 1, 2, 3; Q_CHANGED pulses on each of the next 3 outputs.
- Stall: fill with 3 valid words, then ENABLE=0 for 5 cycles while D toggles → Q, Q_VALID and OCCUPANCY=3 stay frozen and Q_CHANGED=0; after ENABLE=1 the original order resumes.
- Flush while stalled: ENABLE=0, CLEAR=1 for one edge with OCCUPANCY=2 → next cycle Q=RESET_VALUE, Q_VALID=0, OCCUPANCY=0; the D value present that cycle never emerges.
- Bubbles: D_VALID pattern 1,0,1,0 with D=1,2,3,4 → Q_VALID sequence 1,0,1,0 after 3 edges; OCCUPANCY never exceeds 2 and never underflows.
- Repeat data and DEPTH=1: D=8'h5A valid for 3 edges → Q_CHANGED pulses once only; the same bench with DEPTH=1 → latency 1 and OCCUPANCY equals Q_VALID.

Source files
------------

// File: rtl/registrador_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// registrador_pipeline_pkg
// Shared constants for the registrador_pipeline family.
//   DEFAULT_WIDTH : default data word width
//   DEFAULT_DEPTH : default number of pipeline stages
//   occ_width()   : bit width needed to count 0..depth occupied stages
// ---------------------------------------------------------------------------
package registrador_pipeline_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 3;

  // Width of the occupancy counter. $clog2(depth+1) already covers 0..depth;
  // the floor keeps the port at least one bit wide for degenerate depths.
  function automatic int occ_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/registrador_pipeline_estagio.sv
// ---------------------------------------------------------------------------
// estagio_registro
// One pipeline stage: a WIDTH-bit data word plus its valid tag, held in a
// single WIDTH+1-bit register.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, loads {RESET_VALUE, 0}
//   clear   : synchronous flush, loads {RESET_VALUE, 0}; wins over enable
//   enable  : 1 = load {d_data, d_valid}; 0 = hold
//   d_data  : incoming data word
//   d_valid : incoming valid tag
//   q_data  : stored data word
//   q_valid : stored valid tag
// ---------------------------------------------------------------------------
module estagio_registro
  import registrador_pipeline_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid
);

  // Data lives in the upper bits, the valid tag in bit 0.
  localparam logic [WIDTH:0] EMPTY_WORD = {RESET_VALUE, 1'b0};

  logic [WIDTH:0] stage_d;
  logic [WIDTH:0] stage_q;

  // Next-value selection: a flush beats an advance, and with neither the
  // stage simply keeps what it has so a stalled pipeline is frozen.
  always_comb begin
    stage_d = stage_q;
    if (clear) begin
      stage_d = EMPTY_WORD;
    end else if (enable) begin
      stage_d = {d_data, d_valid};
    end
  end

  // The stage register itself; reset is asynchronous so the pipeline empties
  // the moment reset_n falls, without waiting for a clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= EMPTY_WORD;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_data  = stage_q[WIDTH:1];
  assign q_valid = stage_q[0];

endmodule

// File: rtl/registrador_pipeline.sv
// ---------------------------------------------------------------------------
// registrador_pipeline
// WIDTH-bit, DEPTH-stage register pipeline with a valid tag per stage, a
// global stall, a synchronous flush and a running count of occupied stages.
//   CLOCK     : rising-edge clock
//   RESET     : asynchronous active-low reset
//   ENABLE    : 1 = pipeline advances, 0 = every stage holds
//   CLEAR     : synchronous flush (priority over ENABLE)
//   D         : input data word
//   D_VALID   : valid tag for D
//   Q         : data word of the last stage
//   Q_VALID   : valid tag of the last stage
//   OCCUPANCY : number of stages currently holding a valid word
//   Q_CHANGED : one-cycle pulse when the last stage loads valid data that
//               differs from the previous Q
// ---------------------------------------------------------------------------
module registrador_pipeline
  import registrador_pipeline_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               DEPTH       = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        CLOCK,
  input  logic                        RESET,
  input  logic                        ENABLE,
  input  logic                        CLEAR,
  input  logic [WIDTH-1:0]            D,
  input  logic                        D_VALID,
  output logic [WIDTH-1:0]            Q,
  output logic                        Q_VALID,
  output logic [occ_width(DEPTH)-1:0] OCCUPANCY,
  output logic                        Q_CHANGED
);

  localparam int OCC_W = occ_width(DEPTH);

  // Per-stage inputs and outputs. in_*[i] is what stage i loads on an
  // enabled edge, so in_*[DEPTH-1] is exactly what the output stage is
  // about to take in; that is what Q_CHANGED looks at.
  logic [WIDTH-1:0] in_data     [DEPTH];
  logic             in_valid    [DEPTH];
  logic [WIDTH-1:0] stage_data  [DEPTH];
  logic             stage_valid [DEPTH];

  logic [OCC_W-1:0] occupancy_d;
  logic [OCC_W-1:0] occupancy_q;
  logic             q_changed_d;
  logic             q_changed_q;

  // Chain of stages: stage 0 is fed from the ports, every later stage from
  // its predecessor. All stages share enable and clear so they move in
  // lock-step.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign in_data[g]  = D;
      assign in_valid[g] = D_VALID;
    end else begin : g_body
      assign in_data[g]  = stage_data[g-1];
      assign in_valid[g] = stage_valid[g-1];
    end

    estagio_registro #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_estagio (
      .clock   (CLOCK),
      .reset_n (RESET),
      .enable  (ENABLE),
      .clear   (CLEAR),
      .d_data  (in_data[g]),
      .d_valid (in_valid[g]),
      .q_data  (stage_data[g]),
      .q_valid (stage_valid[g])
    );
  end

  // Occupancy tracks the number of set valid tags incrementally: on an
  // advance one tag enters at the head and one leaves at the tail, so the
  // count only moves when those two differ. A flush empties everything.
  always_comb begin
    occupancy_d = occupancy_q;
    if (CLEAR) begin
      occupancy_d = '0;
    end else if (ENABLE) begin
      if (D_VALID && !stage_valid[DEPTH-1]) begin
        occupancy_d = occupancy_q + OCC_W'(1);
      end else if (!D_VALID && stage_valid[DEPTH-1]) begin
        occupancy_d = occupancy_q - OCC_W'(1);
      end
    end
  end

  // Change pulse: raised only on an advancing edge where the output stage
  // takes a valid word whose data differs from the current Q. Invalid words
  // and stalls never raise it, and repeated data leaves it low.
  always_comb begin
    q_changed_d = 1'b0;
    if (!CLEAR && ENABLE && in_valid[DEPTH-1] &&
        (in_data[DEPTH-1] != stage_data[DEPTH-1])) begin
      q_changed_d = 1'b1;
    end
  end

  // Bookkeeping registers next to the stage chain, sharing its asynchronous
  // reset so a reset leaves count and pulse consistent with an empty pipe.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      occupancy_q <= '0;
      q_changed_q <= 1'b0;
    end else begin
      occupancy_q <= occupancy_d;
      q_changed_q <= q_changed_d;
    end
  end

  assign Q         = stage_data[DEPTH-1];
  assign Q_VALID   = stage_valid[DEPTH-1];
  assign OCCUPANCY = occupancy_q;
  assign Q_CHANGED = q_changed_q;

endmodule

// File: tb/tb_registrador_pipeline.sv
// ---------------------------------------------------------------------------
// tb_registrador_pipeline
// Drives a DEPTH=3 and a DEPTH=1 instance (both WIDTH=8, RESET_VALUE=8'hA5)
// from the same inputs and compares them against an array-of-words model.
// ---------------------------------------------------------------------------
module tb_registrador_pipeline;

  localparam logic [7:0] RV = 8'hA5;

  logic       CLOCK;
  logic       RESET;
  logic       ENABLE;
  logic       CLEAR;
  logic [7:0] D;
  logic       D_VALID;

  logic [7:0] q3, q1;
  logic       qv3, qv1;
  logic [1:0] occ3;
  logic [0:0] occ1;
  logic       chg3, chg1;

  int testsRun;
  int failCount;

  // Model state: for each instance, an array of {data, valid} words where
  // index 0 is the newest word; plus the expected change pulse.
  logic [8:0] pipe     [2][3];
  logic       expChg   [2];
  int         depthOf  [2];

  registrador_pipeline #(
    .WIDTH(8), .DEPTH(3), .RESET_VALUE(RV)
  ) dut3 (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .CLEAR(CLEAR),
    .D(D), .D_VALID(D_VALID),
    .Q(q3), .Q_VALID(qv3), .OCCUPANCY(occ3), .Q_CHANGED(chg3)
  );

  registrador_pipeline #(
    .WIDTH(8), .DEPTH(1), .RESET_VALUE(RV)
  ) dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .CLEAR(CLEAR),
    .D(D), .D_VALID(D_VALID),
    .Q(q1), .Q_VALID(qv1), .OCCUPANCY(occ1), .Q_CHANGED(chg1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Empty both model pipelines.
  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 3; i++) pipe[m][i] = {RV, 1'b0};
      expChg[m] = 1'b0;
    end
  endtask

  // Apply one clock edge to the model using the current inputs.
  task automatic modelEdge();
    logic [7:0] oldQ;
    int         dep;
    for (int m = 0; m < 2; m++) begin
      dep = depthOf[m];
      if (CLEAR) begin
        for (int i = 0; i < 3; i++) pipe[m][i] = {RV, 1'b0};
        expChg[m] = 1'b0;
      end else if (ENABLE) begin
        oldQ = pipe[m][dep-1][8:1];
        for (int i = dep - 1; i > 0; i--) pipe[m][i] = pipe[m][i-1];
        pipe[m][0] = {D, D_VALID};
        expChg[m] = pipe[m][dep-1][0] && (pipe[m][dep-1][8:1] != oldQ);
      end else begin
        expChg[m] = 1'b0;
      end
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic checkOutput(input string tag);
    logic [7:0] eq [2];
    logic       ev [2];
    int         eo [2];
    for (int m = 0; m < 2; m++) begin
      eq[m] = pipe[m][depthOf[m]-1][8:1];
      ev[m] = pipe[m][depthOf[m]-1][0];
      eo[m] = 0;
      for (int i = 0; i < depthOf[m]; i++) eo[m] += int'(pipe[m][i][0]);
    end

    testsRun++;
    assert (q3 === eq[0]) else begin
      failCount++;
      $error("[TB] FAIL %s d3.Q observed=%h expected=%h", tag, q3, eq[0]);
    end
    testsRun++;
    assert (qv3 === ev[0]) else begin
      failCount++;
      $error("[TB] FAIL %s d3.Q_VALID observed=%b expected=%b", tag, qv3, ev[0]);
    end
    testsRun++;
    assert (occ3 === 2'(eo[0])) else begin
      failCount++;
      $error("[TB] FAIL %s d3.OCCUPANCY observed=%0d expected=%0d", tag, occ3, eo[0]);
    end
    testsRun++;
    assert (chg3 === expChg[0]) else begin
      failCount++;
      $error("[TB] FAIL %s d3.Q_CHANGED observed=%b expected=%b", tag, chg3, expChg[0]);
    end
    testsRun++;
    assert (q1 === eq[1]) else begin
      failCount++;
      $error("[TB] FAIL %s d1.Q observed=%h expected=%h", tag, q1, eq[1]);
    end
    testsRun++;
    assert (qv1 === ev[1]) else begin
      failCount++;
      $error("[TB] FAIL %s d1.Q_VALID observed=%b expected=%b", tag, qv1, ev[1]);
    end
    testsRun++;
    assert (occ1 === 1'(eo[1])) else begin
      failCount++;
      $error("[TB] FAIL %s d1.OCCUPANCY observed=%0d expected=%0d", tag, occ1, eo[1]);
    end
    testsRun++;
    assert (chg1 === expChg[1]) else begin
      failCount++;
      $error("[TB] FAIL %s d1.Q_CHANGED observed=%b expected=%b", tag, chg1, expChg[1]);
    end
  endtask

  // Drive one cycle of inputs (called 1 time unit after a rising edge),
  // step the model at the next edge, then sample just after that edge.
  task automatic applyStimulus(input logic en, input logic clr,
                               input logic [7:0] d, input logic dv,
                               input string tag);
    ENABLE  = en;
    CLEAR   = clr;
    D       = d;
    D_VALID = dv;
    @(posedge CLOCK);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  // Assert reset in the middle of a cycle, check it took effect without an
  // edge, hold it across one edge, then release it away from the edge.
  task automatic resetMid(input string tag);
    #2;
    RESET = 1'b0;
    modelReset();
    #1;
    checkOutput(tag);
    @(posedge CLOCK);
    #1;
    checkOutput(tag);
    RESET = 1'b1;
  endtask

  initial begin
    testsRun   = 0;
    failCount  = 0;
    depthOf[0] = 3;
    depthOf[1] = 1;
    modelReset();

    // Reset is applied mid-cycle before any edge, with the pipeline being
    // told to advance valid data, and held for three edges.
    RESET   = 1'b1;
    ENABLE  = 1'b1;
    CLEAR   = 1'b0;
    D       = 8'h3C;
    D_VALID = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("reset_async");
    repeat (3) begin
      @(posedge CLOCK);
      #1;
      checkOutput("reset_hold");
    end
    RESET = 1'b1;

    // Latency and change pulses.
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b1, "lat_1");
    applyStimulus(1'b1, 1'b0, 8'h22, 1'b1, "lat_2");
    applyStimulus(1'b1, 1'b0, 8'h33, 1'b1, "lat_3");
    applyStimulus(1'b1, 1'b0, 8'h44, 1'b1, "lat_4");
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b1, "lat_5");
    applyStimulus(1'b1, 1'b0, 8'h66, 1'b1, "lat_6");

    // Stall with toggling D, then resume.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 8'($urandom), 1'($urandom), "stall");
    applyStimulus(1'b1, 1'b0, 8'h77, 1'b1, "resume_1");
    applyStimulus(1'b1, 1'b0, 8'h88, 1'b1, "resume_2");

    // Bring occupancy down to 2, then flush while stalled.
    applyStimulus(1'b1, 1'b0, 8'h99, 1'b0, "to_occ2");
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1, "flush_stalled");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, "post_flush_1");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, "post_flush_2");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, "post_flush_3");

    // Bubbles: valid pattern 1,0,1,0 then drain with invalid zeros.
    applyStimulus(1'b1, 1'b0, 8'h01, 1'b1, "bubble_1");
    applyStimulus(1'b1, 1'b0, 8'h02, 1'b0, "bubble_2");
    applyStimulus(1'b1, 1'b0, 8'h03, 1'b1, "bubble_3");
    applyStimulus(1'b1, 1'b0, 8'h04, 1'b0, "bubble_4");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, "bubble_drain");

    // Repeated data: only the first arrival of 8'h5A should pulse.
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 1'b0, 8'h5A, 1'b1, "repeat");

    // Randomised traffic with occasional flushes and one mid-run reset.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) resetMid("reset_mid");
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                    8'($urandom_range(0, 7)), 1'($urandom), "random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
